// File: rtl/snake_engine_if.sv
// Control, food and readout signals of the snake engine, grouped for port binding.
// The engine binds to the slave modport; the driving side uses master.
interface snake_engine_if #(
    parameter int MAX_LEN = 16,
    parameter int CW      = 12
);
    localparam int LW = $clog2(MAX_LEN);

    logic                 tick;
    logic                 btn_l;
    logic                 btn_r;
    logic                 btn_u;
    logic                 btn_d;
    logic                 start;
    logic                 pause;
    logic signed [CW-1:0] food_x;
    logic signed [CW-1:0] food_y;
    logic                 food_valid;
    logic [LW-1:0]        rd_idx;
    logic signed [CW-1:0] rd_x;
    logic signed [CW-1:0] rd_y;
    logic                 rd_valid;
    logic signed [CW-1:0] head_x;
    logic signed [CW-1:0] head_y;
    logic [LW:0]          length;
    logic [2:0]           state;
    logic                 eat;
    logic                 gg;

    modport master (
        output tick, btn_l, btn_r, btn_u, btn_d, start, pause,
        output food_x, food_y, food_valid, rd_idx,
        input  rd_x, rd_y, rd_valid, head_x, head_y, length, state, eat, gg
    );

    modport slave (
        input  tick, btn_l, btn_r, btn_u, btn_d, start, pause,
        input  food_x, food_y, food_valid, rd_idx,
        output rd_x, rd_y, rd_valid, head_x, head_y, length, state, eat, gg
    );
endinterface

// File: rtl/snake_engine.sv
// Snake game engine: segment store, move/grow FSM, one-segment-per-cycle self-collision
// scan and a registered segment readout port.
module snake_engine #(
    parameter int MAX_LEN  = 16,
    parameter int CW       = 12,
    parameter int STEP     = 36,
    parameter int X_MIN    = -375,
    parameter int X_MAX    = 375,
    parameter int Y_MIN    = -275,
    parameter int Y_MAX    = 225,
    parameter int INIT_LEN = 4,
    parameter int INIT_X   = 108
) (
    input logic           CLK,
    input logic           rst_n,
    snake_engine_if.slave bus
);
    localparam int LW = $clog2(MAX_LEN);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StRun   = 3'd1,
        StCheck = 3'd2,
        StPause = 3'd3,
        StOver  = 3'd4
    } state_e;

    typedef enum logic [1:0] {DirRight, DirLeft, DirUp, DirDown} dir_e;
    typedef logic signed [CW-1:0] coord_t;

    // One extra bit so head +/- STEP near the limits cannot wrap before the bound test.
    localparam logic signed [CW:0] StepW = (CW+1)'(STEP);
    localparam logic signed [CW:0] XMinW = (CW+1)'(X_MIN);
    localparam logic signed [CW:0] XMaxW = (CW+1)'(X_MAX);
    localparam logic signed [CW:0] YMinW = (CW+1)'(Y_MIN);
    localparam logic signed [CW:0] YMaxW = (CW+1)'(Y_MAX);
    localparam logic [LW:0]        LenMax  = (LW+1)'(MAX_LEN);
    localparam logic [LW:0]        LenInit = (LW+1)'(INIT_LEN);
    localparam logic [LW:0]        LenOne  = (LW+1)'(1);

    function automatic coord_t init_x(input int i);
        return (i < INIT_LEN) ? coord_t'(INIT_X - i * STEP) : '0;
    endfunction

    function automatic dir_e reverse(input dir_e d);
        dir_e r;
        unique case (d)
            DirRight: r = DirLeft;
            DirLeft:  r = DirRight;
            DirUp:    r = DirDown;
            DirDown:  r = DirUp;
        endcase
        return r;
    endfunction

    state_e            state_q, state_d;
    dir_e              dir_q, dir_d, steer_dir, req_dir;
    logic              req_vld;
    coord_t            seg_x_q [MAX_LEN];
    coord_t            seg_x_d [MAX_LEN];
    coord_t            seg_y_q [MAX_LEN];
    coord_t            seg_y_d [MAX_LEN];
    logic [LW:0]       length_q, length_d;
    logic [LW-1:0]     idx_q, idx_d;
    logic              eat_q, eat_d;
    logic              rd_valid_q, rd_valid_d;
    coord_t            rd_x_q, rd_x_d, rd_y_q, rd_y_d;
    logic signed [CW:0] nx, ny;
    logic              out_of_bounds, hit_food, any_btn;

    assign any_btn = bus.btn_l | bus.btn_r | bus.btn_u | bus.btn_d;

    // Highest-priority request wins; a reversal request is dropped, not demoted.
    always_comb begin
        steer_dir = dir_q;
        req_dir   = dir_q;
        req_vld   = 1'b1;
        if (bus.btn_l)      req_dir = DirLeft;
        else if (bus.btn_r) req_dir = DirRight;
        else if (bus.btn_u) req_dir = DirUp;
        else if (bus.btn_d) req_dir = DirDown;
        else                req_vld = 1'b0;
        if (req_vld && (req_dir != reverse(dir_q))) steer_dir = req_dir;
    end

    always_comb begin
        nx = {seg_x_q[0][CW-1], seg_x_q[0]};
        ny = {seg_y_q[0][CW-1], seg_y_q[0]};
        unique case (dir_q)
            DirRight: nx = nx + StepW;
            DirLeft:  nx = nx - StepW;
            DirUp:    ny = ny + StepW;
            DirDown:  ny = ny - StepW;
        endcase
        out_of_bounds = (nx <= XMinW) || (nx >= XMaxW) || (ny <= YMinW) || (ny >= YMaxW);
        hit_food = bus.food_valid && (nx[CW-1:0] == bus.food_x) && (ny[CW-1:0] == bus.food_y);
    end

    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        length_d = length_q;
        idx_d    = idx_q;
        eat_d    = 1'b0;
        seg_x_d  = seg_x_q;
        seg_y_d  = seg_y_q;
        case (state_q)
            StIdle: begin
                for (int i = 0; i < MAX_LEN; i++) begin
                    seg_x_d[i] = init_x(i);
                    seg_y_d[i] = '0;
                end
                length_d = LenInit;
                dir_d    = DirRight;
                if (bus.start || any_btn) state_d = StRun;
            end
            StRun: begin
                dir_d = steer_dir;
                if (bus.pause) begin
                    state_d = StPause;
                end else if (bus.tick) begin
                    if (out_of_bounds) begin
                        state_d = StOver;
                    end else begin
                        // Shifting the full array keeps the old tail one slot past length.
                        for (int i = 1; i < MAX_LEN; i++) begin
                            seg_x_d[i] = seg_x_q[i-1];
                            seg_y_d[i] = seg_y_q[i-1];
                        end
                        seg_x_d[0] = nx[CW-1:0];
                        seg_y_d[0] = ny[CW-1:0];
                        if (hit_food) begin
                            eat_d = 1'b1;
                            if (length_q < LenMax) length_d = length_q + LenOne;
                        end
                        idx_d   = LW'(1);
                        state_d = StCheck;
                    end
                end
            end
            StCheck: begin
                dir_d = steer_dir;
                if ((seg_x_q[idx_q] == seg_x_q[0]) && (seg_y_q[idx_q] == seg_y_q[0])) begin
                    state_d = StOver;
                end else if ({1'b0, idx_q} == (length_q - LenOne)) begin
                    state_d = StRun;
                end else begin
                    idx_d = idx_q + LW'(1);
                end
            end
            StPause: begin
                if (!bus.pause) state_d = StRun;
            end
            StOver: begin
                if (bus.start) begin
                    for (int i = 0; i < MAX_LEN; i++) begin
                        seg_x_d[i] = init_x(i);
                        seg_y_d[i] = '0;
                    end
                    length_d = LenInit;
                    dir_d    = DirRight;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        rd_valid_d = ({1'b0, bus.rd_idx} < length_q);
        rd_x_d     = '0;
        rd_y_d     = '0;
        if (rd_valid_d) begin
            rd_x_d = seg_x_q[bus.rd_idx];
            rd_y_d = seg_y_q[bus.rd_idx];
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            dir_q      <= DirRight;
            length_q   <= LenInit;
            idx_q      <= '0;
            eat_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_x_q     <= '0;
            rd_y_q     <= '0;
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x_q[i] <= init_x(i);
                seg_y_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            length_q   <= length_d;
            idx_q      <= idx_d;
            eat_q      <= eat_d;
            rd_valid_q <= rd_valid_d;
            rd_x_q     <= rd_x_d;
            rd_y_q     <= rd_y_d;
            seg_x_q    <= seg_x_d;
            seg_y_q    <= seg_y_d;
        end
    end

    assign bus.state    = state_q;
    assign bus.gg       = (state_q == StOver);
    assign bus.eat      = eat_q;
    assign bus.length   = length_q;
    assign bus.head_x   = seg_x_q[0];
    assign bus.head_y   = seg_y_q[0];
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_x     = rd_x_q;
    assign bus.rd_y     = rd_y_q;
endmodule

// File: tb/tb_snake_engine.sv
// Self-checking bench for snake_engine: directed corner sequences, a steering table and
// randomized play against a queue-based game model.
module tb_snake_engine;
    localparam int MAX_LEN = 16;
    localparam int CW      = 12;
    localparam int STEP    = 36;
    localparam int LW      = $clog2(MAX_LEN);
    localparam int X_MIN = -375, X_MAX = 375, Y_MIN = -275, Y_MAX = 225;
    localparam int S_IDLE = 0, S_RUN = 1, S_CHECK = 2, S_PAUSE = 3, S_OVER = 4;
    localparam logic [3:0] B_L = 4'b1000, B_R = 4'b0100, B_U = 4'b0010, B_D = 4'b0001;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    snake_engine_if #(.MAX_LEN(MAX_LEN), .CW(CW)) bus ();

    snake_engine #(.MAX_LEN(MAX_LEN), .CW(CW)) dut (
        .CLK  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    typedef struct {int x; int y;} pt_t;
    pt_t snake[$];
    int  m_dir;
    bit  m_over;
    int  dxs[4] = '{1, -1, 0, 0};   // 0 right, 1 left, 2 up, 3 down
    int  dys[4] = '{0, 0, 1, -1};

    typedef struct {logic [3:0] btn; int ex; int ey;} vec_t;
    vec_t vecs[10];

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        {bus.tick, bus.btn_l, bus.btn_r, bus.btn_u, bus.btn_d, bus.start, bus.pause} = '0;
        bus.food_x = '0; bus.food_y = '0; bus.food_valid = 1'b0; bus.rd_idx = '0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic start_game();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic tick_once();
        bus.tick = 1'b1;
        step();
        bus.tick = 1'b0;
    endtask

    task automatic apply_btn(input logic [3:0] b);
        {bus.btn_l, bus.btn_r, bus.btn_u, bus.btn_d} = b;
        step();
        {bus.btn_l, bus.btn_r, bus.btn_u, bus.btn_d} = '0;
    endtask

    task automatic set_food(input int x, input int y, input logic v);
        bus.food_x = CW'(x); bus.food_y = CW'(y); bus.food_valid = v;
    endtask

    task automatic wait_state(input int s, input string name);
        int n = 0;
        while (int'(bus.state) != s && n < 200) begin
            step();
            n++;
        end
        chk(name, bus.state, s);
    endtask

    task automatic check_seg(input string name, input int idx, input int ex, input int ey,
                             input bit ev);
        bus.rd_idx = LW'(idx);
        step();
        chk({name, " valid"}, bus.rd_valid, ev);
        chk({name, " x"}, bus.rd_x, ex);
        chk({name, " y"}, bus.rd_y, ey);
    endtask

    task automatic check_head(input string name, input int ex, input int ey);
        chk({name, " head_x"}, bus.head_x, ex);
        chk({name, " head_y"}, bus.head_y, ey);
    endtask

    function automatic int pick_dir(input logic [3:0] b, input int cur);
        int req;
        if (b[3]) req = 1;
        else if (b[2]) req = 0;
        else if (b[1]) req = 2;
        else if (b[0]) req = 3;
        else return cur;
        if (dxs[req] + dxs[cur] == 0 && dys[req] + dys[cur] == 0) return cur;
        return req;
    endfunction

    task automatic model_init();
        pt_t p;
        snake.delete();
        for (int i = 0; i < 4; i++) begin
            p.x = 108 - i * STEP; p.y = 0;
            snake.push_back(p);
        end
        m_dir = 0;
        m_over = 1'b0;
    endtask

    task automatic model_tick(input int fx, input int fy, input bit fv, output bit ate);
        pt_t p;
        int keep;
        p.x = snake[0].x + dxs[m_dir] * STEP;
        p.y = snake[0].y + dys[m_dir] * STEP;
        ate = 1'b0;
        if (p.x <= X_MIN || p.x >= X_MAX || p.y <= Y_MIN || p.y >= Y_MAX) begin
            m_over = 1'b1;
            return;
        end
        ate  = fv && p.x == fx && p.y == fy;
        keep = snake.size();
        if (ate && keep < MAX_LEN) keep++;
        snake.push_front(p);
        while (snake.size() > keep) void'(snake.pop_back());
        for (int i = 1; i < snake.size(); i++)
            if (snake[i].x == p.x && snake[i].y == p.y) m_over = 1'b1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, " state"}, bus.state, m_over ? S_OVER : S_RUN);
        chk({tag, " gg"}, bus.gg, m_over);
        chk({tag, " length"}, bus.length, snake.size());
        check_head(tag, snake[0].x, snake[0].y);
        for (int i = 0; i < MAX_LEN; i++) begin
            if (i < snake.size()) check_seg($sformatf("%s seg%0d", tag, i), i, snake[i].x,
                                            snake[i].y, 1'b1);
            else check_seg($sformatf("%s seg%0d", tag, i), i, 0, 0, 1'b0);
        end
    endtask

    task automatic build_u();
        do_reset();
        start_game();
        set_food(144, 0, 1'b1);
        tick_once();
        bus.food_valid = 1'b0;
        wait_state(S_RUN, "u grow run");
        apply_btn(B_U); tick_once(); wait_state(S_RUN, "u up run");
        apply_btn(B_L); tick_once(); wait_state(S_RUN, "u left run");
        apply_btn(B_D); tick_once();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, fx, fy, pnx, pny;
        bit fv, ate;
        logic [3:0] b;

        vecs[0] = '{4'b0000, 144, 0};
        vecs[1] = '{B_L, 180, 0};
        vecs[2] = '{B_U, 180, 36};
        vecs[3] = '{B_D, 180, 72};
        vecs[4] = '{B_L | B_R, 144, 72};
        vecs[5] = '{B_R, 108, 72};
        vecs[6] = '{B_U | B_D, 108, 108};
        vecs[7] = '{B_D, 108, 144};
        vecs[8] = '{B_R | B_U | B_D, 144, 144};
        vecs[9] = '{B_L | B_D, 180, 144};

        // Reset values and readout
        do_reset();
        rst_n = 1'b0;
        step();
        chk("reset rd_valid", bus.rd_valid, 0);
        chk("reset gg", bus.gg, 0);
        chk("reset eat", bus.eat, 0);
        rst_n = 1'b1;
        bus.rd_idx = LW'(3);
        step();
        chk("reset state", bus.state, S_IDLE);
        chk("reset length", bus.length, 4);
        check_head("reset", 108, 0);
        chk("reset rd3 x", bus.rd_x, 0);
        chk("reset rd3 y", bus.rd_y, 0);
        chk("reset rd3 valid", bus.rd_valid, 1);
        check_seg("reset seg1", 1, 72, 0, 1'b1);
        check_seg("reset seg4", 4, 0, 0, 1'b0);

        // First move and CHECK duration
        start_game();
        chk("start run", bus.state, S_RUN);
        tick_once();
        chk("tick check", bus.state, S_CHECK);
        cnt = 0;
        while (int'(bus.state) == S_CHECK && cnt < 100) begin cnt++; step(); end
        chk("check cycles", cnt, 3);
        chk("check to run", bus.state, S_RUN);
        check_head("move1", 144, 0);
        check_seg("move1 seg1", 1, 108, 0, 1'b1);

        // Steering table: priority and reversal
        do_reset();
        start_game();
        foreach (vecs[k]) begin
            apply_btn(vecs[k].btn);
            tick_once();
            wait_state(S_RUN, $sformatf("vec%0d run", k));
            check_head($sformatf("vec%0d", k), vecs[k].ex, vecs[k].ey);
        end

        // Pause drops ticks
        do_reset();
        start_game();
        bus.pause = 1'b1;
        step();
        chk("pause state", bus.state, S_PAUSE);
        tick_once();
        step();
        chk("pause hold", bus.state, S_PAUSE);
        check_head("pause", 108, 0);
        bus.pause = 1'b0;
        step();
        chk("unpause", bus.state, S_RUN);
        tick_once();
        wait_state(S_RUN, "unpause tick run");
        check_head("unpause", 144, 0);

        // Eat, wall hit, restart
        do_reset();
        start_game();
        set_food(144, 0, 1'b1);
        tick_once();
        chk("eat pulse", bus.eat, 1);
        bus.food_valid = 1'b0;
        step();
        chk("eat one cycle", bus.eat, 0);
        wait_state(S_RUN, "eat run");
        chk("eat length", bus.length, 5);
        check_seg("eat seg4", 4, 0, 0, 1'b1);
        for (int k = 2; k <= 7; k++) begin
            tick_once();
            wait_state(S_RUN, $sformatf("wall tick%0d", k));
        end
        check_head("pre wall", 360, 0);
        tick_once();
        chk("wall over", bus.state, S_OVER);
        chk("wall gg", bus.gg, 1);
        check_head("wall", 360, 0);
        chk("wall length", bus.length, 5);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("restart idle", bus.state, S_IDLE);
        chk("restart gg", bus.gg, 0);
        chk("restart length", bus.length, 4);
        check_head("restart", 108, 0);
        step();
        chk("idle holds", bus.state, S_IDLE);
        apply_btn(B_U);
        chk("button leaves idle", bus.state, S_RUN);
        tick_once();
        wait_state(S_RUN, "restart tick run");
        check_head("restart move", 144, 0);

        // Self-collision in a U turn, then the same with reset mid-CHECK
        build_u();
        cnt = 0;
        while (int'(bus.state) == S_CHECK && cnt < 100) begin cnt++; step(); end
        chk("u check cycles", cnt, 4);
        chk("u over", bus.state, S_OVER);
        chk("u gg", bus.gg, 1);
        check_head("u", 108, 0);
        build_u();
        step();
        chk("mid check", bus.state, S_CHECK);
        rst_n = 1'b0;
        #1;
        chk("async state", bus.state, S_IDLE);
        chk("async length", bus.length, 4);
        chk("async gg", bus.gg, 0);
        chk("async eat", bus.eat, 0);
        chk("async rd_valid", bus.rd_valid, 0);
        check_head("async", 108, 0);
        step();
        rst_n = 1'b1;
        step();
        chk("post reset idle", bus.state, S_IDLE);

        // Growth to saturation along an L-shaped path
        do_reset();
        model_init();
        start_game();
        for (int k = 0; k < 13; k++) begin
            if (k == 7) begin
                apply_btn(B_U);
                m_dir = pick_dir(B_U, m_dir);
            end
            fx = snake[0].x + dxs[m_dir] * STEP;
            fy = snake[0].y + dys[m_dir] * STEP;
            set_food(fx, fy, 1'b1);
            tick_once();
            model_tick(fx, fy, 1'b1, ate);
            chk($sformatf("sat eat%0d", k), bus.eat, 1);
            wait_state(S_RUN, $sformatf("sat run%0d", k));
            chk($sformatf("sat len%0d", k), bus.length, (k + 5 > MAX_LEN) ? MAX_LEN : k + 5);
        end
        bus.food_valid = 1'b0;
        check_model("sat");

        // Randomized play against the model
        do_reset();
        model_init();
        start_game();
        for (int it = 0; it < 80; it++) begin
            if (m_over) begin
                bus.start = 1'b1; step(); bus.start = 1'b0;
                chk("rnd restart idle", bus.state, S_IDLE);
                bus.start = 1'b1; step(); bus.start = 1'b0;
                chk("rnd restart run", bus.state, S_RUN);
                model_init();
            end
            b = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 0) b = '0;
            apply_btn(b);
            m_dir = pick_dir(b, m_dir);
            pnx = snake[0].x + dxs[m_dir] * STEP;
            pny = snake[0].y + dys[m_dir] * STEP;
            case ($urandom_range(0, 2))
                0: begin fx = pnx; fy = pny; fv = 1'b1; end
                1: begin
                    fx = 108 + STEP * (int'($urandom_range(0, 8)) - 4);
                    fy = STEP * (int'($urandom_range(0, 8)) - 4);
                    fv = 1'b1;
                end
                default: begin fx = pnx; fy = pny; fv = 1'b0; end
            endcase
            set_food(fx, fy, fv);
            tick_once();
            model_tick(fx, fy, fv, ate);
            chk($sformatf("rnd%0d eat", it), bus.eat, ate);
            bus.food_valid = 1'b0;
            for (int w = 0; w < MAX_LEN + 4; w++) step();
            check_model($sformatf("rnd%0d", it));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
